// File: rtl/move_msg_tx.sv
// Packs a move-control command into a 24-bit even-parity frame and sends it
// as four 6-bit beats over a four-phase req/ack link to the peer board.
module move_msg_tx #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       interboard_rst,
  input  logic       ctrl_en,
  input  logic [3:0] ctrl_msg_type,
  input  logic [4:0] ctrl_block_x,
  input  logic [2:0] ctrl_block_y,
  input  logic [5:0] ctrl_card,
  input  logic [2:0] ctrl_sel_len,
  input  logic       ctrl_move_dir,
  input  logic       inter_ack,
  output logic       inter_req,
  output logic [5:0] inter_data,
  output logic       inter_ready,
  output logic       tx_busy,
  output logic       tx_err
);

  localparam int unsigned FRAME_W = 24;
  localparam int unsigned BEAT_W  = 6;
  localparam int unsigned SYNC_N  = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int unsigned TO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEND    = 3'd1,
    S_RELEASE = 3'd2,
    S_DONE    = 3'd3,
    S_ERR     = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [FRAME_W-1:0]  frame_q, frame_d;
  logic [1:0]          beat_q, beat_d;
  logic [TO_W-1:0]     to_q, to_d;
  logic [SYNC_N-1:0]   sync_q, sync_d;
  logic [BEAT_W-1:0]   data_q, data_d;
  logic                req_q, req_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic [FRAME_W-1:0]  frame_new;
  logic                ack_s;

  function automatic logic [BEAT_W-1:0] beat_of(input logic [FRAME_W-1:0] f,
                                                input logic [1:0] k);
    case (k)
      2'd0:    beat_of = f[5:0];
      2'd1:    beat_of = f[11:6];
      2'd2:    beat_of = f[17:12];
      default: beat_of = f[23:18];
    endcase
  endfunction

  assign ack_s = sync_q[SYNC_N-1];

  // Field packing; bit 22 makes parity over [22:0] even, bit 23 stays zero.
  always_comb begin
    frame_new = {2'b00, ctrl_move_dir, ctrl_sel_len, ctrl_card,
                 ctrl_block_y, ctrl_block_x, ctrl_msg_type};
    frame_new[22] = ^frame_new[21:0];
  end

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    beat_d  = beat_q;
    to_d    = to_q;
    data_d  = data_q;
    sync_d  = {sync_q[SYNC_N-2:0], inter_ack};

    case (state_q)
      S_IDLE: begin
        if (ctrl_en) begin
          frame_d = frame_new;
          beat_d  = 2'd0;
          to_d    = '0;
          data_d  = frame_new[5:0];
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (ack_s) begin
          to_d    = '0;
          state_d = S_RELEASE;
        end else if (to_q == TO_LAST) begin
          state_d = S_ERR;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      S_RELEASE: begin
        if (!ack_s) begin
          if (beat_q == 2'd3) begin
            state_d = S_DONE;
          end else begin
            beat_d  = beat_q + 2'd1;
            data_d  = beat_of(frame_q, beat_q + 2'd1);
            to_d    = '0;
            state_d = S_SEND;
          end
        end else if (to_q == TO_LAST) begin
          state_d = S_ERR;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Soft reset from the peer link overrides everything, including ctrl_en.
    if (interboard_rst) begin
      state_d = S_IDLE;
      frame_d = '0;
      beat_d  = 2'd0;
      to_d    = '0;
      data_d  = '0;
      sync_d  = '0;
    end

    req_d   = (state_d == S_SEND);
    ready_d = (state_d == S_DONE);
    err_d   = (state_d == S_ERR);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      frame_q <= '0;
      beat_q  <= 2'd0;
      to_q    <= '0;
      sync_q  <= '0;
      data_q  <= '0;
      req_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      beat_q  <= beat_d;
      to_q    <= to_d;
      sync_q  <= sync_d;
      data_q  <= data_d;
      req_q   <= req_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign inter_req   = req_q;
  assign inter_data  = data_q;
  assign inter_ready = ready_q;
  assign tx_busy     = busy_q;
  assign tx_err      = err_q;

endmodule

// File: doc/move_msg_tx.md
Name: move_msg_tx

Overview:
- Downstream of the per-player move handler. Consumes its move-control command (en, msg_type, block_x/y, card, sel_len, move_dir) and packs it into a 24-bit parity-protected frame.
- Sends the frame to the other board as four 6-bit beats over a four-phase req/ack link.
- Pulses inter_ready when the frame has been fully acknowledged. This pulse is the handshake the move handler waits on in its WAIT_SEND states.

Parameters:
- TIMEOUT_CYCLES, 1_000_000: max cycles spent waiting for any single ack edge before aborting the frame.
- SYNC_STAGES, 2: flip-flop stages on the incoming ack (minimum 2).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset (asserted when 0)
- interboard_rst  input  1  synchronous active-high soft reset; same effect as rst
- ctrl_en  input  1  one-cycle command strobe
- ctrl_msg_type  input  4  message type
- ctrl_block_x  input  5  block column
- ctrl_block_y  input  3  block row
- ctrl_card  input  6  card code
- ctrl_sel_len  input  3  selection length
- ctrl_move_dir  input  1  move direction
- inter_ack  input  1  ack from the peer board (asynchronous)
- inter_req  output  1  request to the peer board
- inter_data  output  6  beat data to the peer board
- inter_ready  output  1  one-cycle pulse: frame delivered
- tx_busy  output  1  high whenever the state is not IDLE
- tx_err  output  1  one-cycle pulse: frame aborted on timeout

Behaviour:
- Reset (rst low, or interboard_rst high at a clock edge):
  - state = IDLE; all outputs = 0.
  - Frame register, beat counter, timeout counter and ack synchronizer cleared.
  - Reset during a transfer abandons the frame; no inter_ready and no tx_err is produced.
- Frame packing, captured on ctrl_en in IDLE:
  - frame[3:0] = msg_type; [8:4] = block_x; [11:9] = block_y; [17:12] = card; [20:18] = sel_len; [21] = move_dir.
  - frame[22] = XOR of frame[21:0], giving even parity over [22:0].
  - frame[23] = 0.
- Beat k (k = 0..3) = frame[6k+5:6k]; beats go out LSB-first.
- Ack path: inter_ack passes through SYNC_STAGES flops; ack_s is the synchronized value. All decisions use ack_s only.
- States:
  - IDLE:
    - inter_req = 0.
    - On ctrl_en: latch the frame, beat = 0, go to SEND.
  - SEND:
    - inter_data = beat k, registered and stable for the whole state; inter_req = 1.
    - On ack_s = 1, go to RELEASE.
  - RELEASE:
    - inter_req = 0; inter_data is held.
    - On ack_s = 0: if beat == 3 go to DONE, else beat += 1 and go to SEND.
  - DONE: inter_ready = 1 for exactly one cycle, then IDLE.
  - ERR: tx_err = 1 for exactly one cycle, inter_req = 0, then IDLE.
- Timing:
  - inter_req rises the cycle after ctrl_en is sampled.
  - inter_data is valid no later than the same edge on which inter_req rises.
- Timeout:
  - The counter clears on every SEND or RELEASE entry and increments each cycle spent in SEND or RELEASE.
  - Reaching TIMEOUT_CYCLES-1 without the awaited ack_s level moves the block to ERR.
- ctrl_en outside IDLE is ignored: no queueing, and the latched frame is unchanged. Callers must gate on tx_busy.
- ctrl_en and a reset in the same cycle: reset wins.
- ack_s already 1 on SEND entry (peer stuck high): treated as ack, so the block proceeds to RELEASE and then waits or times out there.
- Minimum frame latency with zero-delay ack: 4 × (2 handshake cycles + 2·SYNC_STAGES) + 1 cycles from the ctrl_en edge to the inter_ready pulse.

Test Plan:
- Basic frame: ctrl_en with msg_type=3, x=5, y=2, card=17, sel_len=0, dir=0; peer acks each req after 3 cycles -> beats 0x13, 0x11, 0x11, 0x10 in order; exactly one inter_ready pulse; tx_busy drops the cycle after that pulse.
- Parity: msg_type=1, x=0, y=0, card=0, sel_len=0, dir=0 -> beat3 = 0x10 (parity 1). All fields 0 -> all four beats 0x00.
- Busy rejection: second ctrl_en (card=9) during beat 1 -> the transmitted frame is still the first one; only one inter_ready pulse.
- Timeout (TIMEOUT_CYCLES=16): peer never acks -> inter_req high for 16 cycles, then one tx_err pulse, inter_req = 0, back in IDLE with no inter_ready.
- Mid-frame reset: assert rst low during beat 2 -> inter_req, inter_data, tx_busy and inter_ready go to 0 immediately (asynchronous). After release, a new ctrl_en sends beat 0 correctly.
- Stuck-high ack: inter_ack held at 1 before ctrl_en -> block moves SEND→RELEASE and then times out in RELEASE with tx_err; no inter_ready.
